// File: rtl/cam_pkg.sv
// Shared FSM encoding, output-format constants and elaboration helpers
// for the OV7670 capture front end.
package cam_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LINE_WAIT,
    ST_BYTE0,
    ST_BYTE1,
    ST_LINE_END
  } cam_state_e;

  localparam int FMT_RGB332 = 0;
  localparam int FMT_RGB444 = 1;
  localparam int FMT_RGB565 = 2;
  localparam int FMT_GRAY8  = 3;

  function automatic int fmt_dw(input int fmt);
    case (fmt)
      FMT_RGB444: return 12;
      FMT_RGB565: return 16;
      default:    return 8;
    endcase
  endfunction

  function automatic bit dec_legal(input int dec);
    return (dec == 1) || (dec == 2) || (dec == 4);
  endfunction

endpackage

// File: rtl/cam_px_pack.sv
// Combinational RGB565 byte-pair to output-format packer; channels keep
// their MSBs. Shared with the test-pattern generator.
module cam_px_pack
  import cam_pkg::*;
#(
  parameter int FMT = FMT_RGB332,
  parameter int DW  = 8
) (
  input  logic [7:0]    i_byte0,
  input  logic [7:0]    i_byte1,
  output logic [DW-1:0] o_px
);

  logic [4:0] w_r;
  logic [5:0] w_g;
  logic [4:0] w_b;
  logic       w_unused_bits;

  assign w_r = i_byte0[7:3];
  assign w_g = {i_byte0[2:0], i_byte1[7:5]};
  assign w_b = i_byte1[4:0];

  // Formats that truncate leave channel LSBs unread.
  assign w_unused_bits = ^{w_r, w_g, w_b};

  generate
    if (FMT == FMT_RGB444) begin : g_rgb444
      assign o_px = {w_r[4:1], w_g[5:2], w_b[4:1]};
    end else if (FMT == FMT_RGB565) begin : g_rgb565
      assign o_px = {i_byte0, i_byte1};
    end else if (FMT == FMT_GRAY8) begin : g_gray8
      assign o_px = {w_g, 2'b00};
    end else begin : g_rgb332
      assign o_px = {w_r[4:2], w_g[5:3], w_b[4:3]};
    end
  endgenerate

endmodule

// File: rtl/cam_capture.sv
// OV7670 capture front end: byte-pair assembly, 1/2/4 decimation, raster
// addressing and frame/line status, all in the camera pixel clock domain.
module cam_capture
  import cam_pkg::*;
#(
  parameter int AW    = 15,
  parameter int FMT   = FMT_RGB332,
  parameter int DW    = 8,
  parameter int H_RES = 160,
  parameter int V_RES = 120,
  parameter int DEC   = 1
) (
  input  logic          pclk,
  input  logic          rst,
  input  logic          vsync,
  input  logic          href,
  input  logic [7:0]    px_data,
  input  logic          capture_en,
  output logic [AW-1:0] mem_px_addr,
  output logic [DW-1:0] mem_px_data,
  output logic          px_wr,
  output logic          frame_done,
  output logic          line_err,
  output logic [7:0]    frame_cnt,
  output logic          busy
);

  localparam int LINE_PX = H_RES * DEC;
  localparam int CW      = $clog2(H_RES + 1);
  localparam int RW      = $clog2(V_RES + 1);
  localparam int PCW     = $clog2(LINE_PX + 2);
  localparam int DCW     = (DEC > 1) ? $clog2(DEC) : 1;

  if (!dec_legal(DEC)) begin : g_bad_dec
    $error("cam_capture: DEC must be 1, 2 or 4");
  end
  if (DW != fmt_dw(FMT)) begin : g_bad_dw
    $error("cam_capture: DW does not match FMT");
  end
  if (H_RES * V_RES > 2 ** AW) begin : g_bad_aw
    $error("cam_capture: H_RES*V_RES does not fit in AW bits");
  end

  cam_state_e     r_state;
  logic           r_vsync_q;
  logic [7:0]     r_byte0;
  logic           r_odd;
  logic [CW-1:0]  r_col;
  logic [RW-1:0]  r_row;
  logic [DCW-1:0] r_hdec;
  logic [DCW-1:0] r_vdec;
  logic [AW-1:0]  r_base;
  logic [PCW-1:0] r_cam_px;

  logic           w_vs_rise;
  logic           w_vs_fall;
  logic           w_line_kept;
  logic           w_px_keep;
  logic [DW-1:0]  w_px;

  assign w_vs_rise   = vsync & ~r_vsync_q;
  assign w_vs_fall   = ~vsync & r_vsync_q;
  assign w_line_kept = (r_vdec == '0) && (r_row < RW'(V_RES));
  assign w_px_keep   = w_line_kept && (r_hdec == '0) && (r_col < CW'(H_RES));

  cam_px_pack #(.FMT(FMT), .DW(DW)) u_pack (
    .i_byte0 (r_byte0),
    .i_byte1 (px_data),
    .o_px    (w_px)
  );

  always_ff @(posedge pclk) begin
    // NOTE: all state uses non-blocking assignments so every branch below
    // reads the pre-edge values, independent of statement order.
    if (rst) begin
      r_state     <= ST_IDLE;
      r_vsync_q   <= 1'b1;
      r_byte0     <= '0;
      r_odd       <= 1'b0;
      r_col       <= '0;
      r_row       <= '0;
      r_hdec      <= '0;
      r_vdec      <= '0;
      r_base      <= '0;
      r_cam_px    <= '0;
      mem_px_addr <= '0;
      mem_px_data <= '0;
      px_wr       <= 1'b0;
      frame_done  <= 1'b0;
      line_err    <= 1'b0;
      frame_cnt   <= '0;
      busy        <= 1'b0;
    end else begin
      r_vsync_q  <= vsync;
      px_wr      <= 1'b0;
      frame_done <= 1'b0;

      if (r_state != ST_IDLE && w_vs_rise) begin
        r_state    <= ST_IDLE;
        frame_done <= 1'b1;
        frame_cnt  <= frame_cnt + 8'd1;
        busy       <= 1'b0;
      end else begin
        case (r_state)
          ST_IDLE: begin
            if (w_vs_fall && capture_en) begin
              r_state  <= ST_LINE_WAIT;
              r_col    <= '0;
              r_row    <= '0;
              r_hdec   <= '0;
              r_vdec   <= '0;
              r_base   <= '0;
              r_cam_px <= '0;
              r_odd    <= 1'b0;
              line_err <= 1'b0;
              busy     <= 1'b1;
            end
          end
          ST_LINE_WAIT, ST_BYTE0: begin
            if (href) begin
              r_byte0 <= px_data;
              r_odd   <= 1'b1;
              r_state <= ST_BYTE1;
            end else if (r_state == ST_BYTE0) begin
              r_state <= ST_LINE_END;
            end
          end
          ST_BYTE1: begin
            if (href) begin
              if (w_px_keep) begin
                mem_px_addr <= r_base + AW'(r_col);
                mem_px_data <= w_px;
                px_wr       <= 1'b1;
                r_col       <= r_col + 1'b1;
              end
              r_hdec   <= (r_hdec == DCW'(DEC - 1)) ? '0 : r_hdec + 1'b1;
              r_cam_px <= (r_cam_px == '1) ? r_cam_px : r_cam_px + 1'b1;
              r_odd    <= 1'b0;
              r_state  <= ST_BYTE0;
            end else begin
              r_state <= ST_LINE_END;
            end
          end
          ST_LINE_END: begin
            if (w_line_kept && (r_odd || r_cam_px != PCW'(LINE_PX))) begin
              line_err <= 1'b1;
            end
            // Row and base saturate once past the last output line.
            if (r_vdec == DCW'(DEC - 1)) begin
              r_vdec <= '0;
              if (r_row < RW'(V_RES)) begin
                r_row  <= r_row + 1'b1;
                r_base <= r_base + AW'(H_RES);
              end
            end else begin
              r_vdec <= r_vdec + 1'b1;
            end
            r_col    <= '0;
            r_hdec   <= '0;
            r_cam_px <= '0;
            r_odd    <= 1'b0;
            r_state  <= ST_LINE_WAIT;
          end
          default: r_state <= ST_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_cam_capture.sv
// Bench for cam_capture: table-driven packer vectors for all formats plus
// scoreboarded frame sequences on a small RGB565, DEC=2 instance.
module tb_cam_capture;

  localparam int AW    = 6;
  localparam int FMT   = 2;
  localparam int DW    = 16;
  localparam int H_RES = 8;
  localparam int V_RES = 4;
  localparam int DEC   = 2;
  localparam int CAM_W = H_RES * DEC;

  logic          pclk = 1'b0;
  logic          rst = 1'b1;
  logic          vsync = 1'b1;
  logic          href = 1'b0;
  logic [7:0]    px_data = '0;
  logic          capture_en = 1'b0;
  logic [AW-1:0] mem_px_addr;
  logic [DW-1:0] mem_px_data;
  logic          px_wr;
  logic          frame_done;
  logic          line_err;
  logic [7:0]    frame_cnt;
  logic          busy;

  cam_capture #(
    .AW(AW), .FMT(FMT), .DW(DW), .H_RES(H_RES), .V_RES(V_RES), .DEC(DEC)
  ) dut (
    .pclk        (pclk),
    .rst         (rst),
    .vsync       (vsync),
    .href        (href),
    .px_data     (px_data),
    .capture_en  (capture_en),
    .mem_px_addr (mem_px_addr),
    .mem_px_data (mem_px_data),
    .px_wr       (px_wr),
    .frame_done  (frame_done),
    .line_err    (line_err),
    .frame_cnt   (frame_cnt),
    .busy        (busy)
  );

  logic [7:0]  pk_b0 = '0;
  logic [7:0]  pk_b1 = '0;
  logic [7:0]  pk_332;
  logic [11:0] pk_444;
  logic [15:0] pk_565;
  logic [7:0]  pk_gray;

  cam_px_pack #(.FMT(0), .DW(8))  u_pk332  (.i_byte0(pk_b0), .i_byte1(pk_b1), .o_px(pk_332));
  cam_px_pack #(.FMT(1), .DW(12)) u_pk444  (.i_byte0(pk_b0), .i_byte1(pk_b1), .o_px(pk_444));
  cam_px_pack #(.FMT(2), .DW(16)) u_pk565  (.i_byte0(pk_b0), .i_byte1(pk_b1), .o_px(pk_565));
  cam_px_pack #(.FMT(3), .DW(8))  u_pkgray (.i_byte0(pk_b0), .i_byte1(pk_b1), .o_px(pk_gray));

  typedef struct {
    logic [7:0]  b0;
    logic [7:0]  b1;
    logic [7:0]  e332;
    logic [11:0] e444;
    logic [15:0] e565;
    logic [7:0]  egray;
  } pack_vec_t;

  typedef struct {
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
  } wr_exp_t;

  wr_exp_t sb_q[$];
  wr_exp_t mon_e;

  int n_checks = 0;
  int n_errors = 0;
  int wr_cnt   = 0;
  int done_cnt = 0;
  int max_addr = -1;
  bit cap_on   = 1'b0;
  bit exp_err  = 1'b0;
  int line_len[16];

  always #5 pclk = ~pclk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge pclk);
    #1;
  endtask

  // Write monitor: pops the scoreboard on every strobe, sampled mid-cycle.
  always @(negedge pclk) begin
    if (px_wr === 1'b1) begin
      wr_cnt++;
      if (int'(mem_px_addr) > max_addr) max_addr = int'(mem_px_addr);
      if (sb_q.size() == 0) begin
        check("unexpected_write", 32'(mem_px_addr), 32'hFFFF_FFFF);
      end else begin
        mon_e = sb_q.pop_front();
        check("wr_addr", 32'(mem_px_addr), 32'(mon_e.addr));
        check("wr_data", 32'(mem_px_data), 32'(mon_e.data));
      end
    end
    if (frame_done === 1'b1) done_cnt++;
  end

  // Camera pixel (x, y) carries byte0 = y, byte1 = x, i.e. RGB565 {y, x}.
  task automatic drive_line(input int y, input int nb, input int blank);
    int  x;
    bit  keep;
    for (int b = 0; b < nb; b++) begin
      x       = b / 2;
      href    = 1'b1;
      px_data = (b % 2 == 0) ? 8'(y) : 8'(x);
      keep    = cap_on && (b % 2 == 1) && (y % DEC == 0) && (y / DEC < V_RES) &&
                (x % DEC == 0) && (x / DEC < H_RES);
      if (keep) sb_q.push_back('{addr: AW'((y / DEC) * H_RES + x / DEC), data: {8'(y), 8'(x)}});
      step();
      if (keep) check("wr_latency", 32'(px_wr), 32'd1);
    end
    if (cap_on && (y % DEC == 0) && (y / DEC < V_RES) && ((nb % 2 != 0) || (nb / 2 != CAM_W)))
      exp_err = 1'b1;
    href = 1'b0;
    repeat (blank) step();
  endtask

  task automatic run_frame(input bit en, input int n_lines);
    capture_en = en;
    vsync      = 1'b1;
    href       = 1'b0;
    repeat (3) step();
    vsync = 1'b0;
    step();
    cap_on   = en;
    wr_cnt   = 0;
    max_addr = -1;
    if (en) exp_err = 1'b0;
    capture_en = 1'b0;
    step();
    for (int y = 0; y < n_lines; y++) begin
      drive_line(y, line_len[y], 3);
      check("line_err", 32'(line_err), 32'(exp_err));
      if (y == 0) check("busy_in_frame", 32'(busy), 32'(en));
    end
    vsync = 1'b1;
    step();
    step();
    cap_on = 1'b0;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_px_wr"},      32'(px_wr),       32'd0);
    check({tag, "_frame_done"}, 32'(frame_done),  32'd0);
    check({tag, "_line_err"},   32'(line_err),    32'd0);
    check({tag, "_frame_cnt"},  32'(frame_cnt),   32'd0);
    check({tag, "_busy"},       32'(busy),        32'd0);
    check({tag, "_addr"},       32'(mem_px_addr), 32'd0);
    check({tag, "_data"},       32'(mem_px_data), 32'd0);
  endtask

  initial begin
    pack_vec_t vecs[5];
    int        done_before;

    vecs[0] = '{8'hF8, 8'h1F, 8'hE3, 12'hF0F, 16'hF81F, 8'h00};
    vecs[1] = '{8'h07, 8'hE0, 8'h1C, 12'h0F0, 16'h07E0, 8'hFC};
    vecs[2] = '{8'h12, 8'h34, 8'h0A, 12'h14A, 16'h1234, 8'h44};
    vecs[3] = '{8'hFF, 8'hFF, 8'hFF, 12'hFFF, 16'hFFFF, 8'hFC};
    vecs[4] = '{8'hA5, 8'h5A, 8'hB7, 12'hAAD, 16'hA55A, 8'hA8};

    for (int i = 0; i < 5; i++) begin
      pk_b0 = vecs[i].b0;
      pk_b1 = vecs[i].b1;
      #1;
      check("pack_rgb332", 32'(pk_332),  32'(vecs[i].e332));
      check("pack_rgb444", 32'(pk_444),  32'(vecs[i].e444));
      check("pack_rgb565", 32'(pk_565),  32'(vecs[i].e565));
      check("pack_gray8",  32'(pk_gray), 32'(vecs[i].egray));
    end

    repeat (3) step();
    check_all_zero("reset");
    rst = 1'b0;
    step();

    for (int y = 0; y < 16; y++) line_len[y] = 2 * CAM_W;

    // Frame 1 skipped: capture_en low at the vsync fall.
    run_frame(1'b0, 8);
    check("f1_writes", wr_cnt, 0);
    check("f1_done", done_cnt, 0);
    check("f1_frame_cnt", 32'(frame_cnt), 32'd0);

    // Frame 2: clean 16x8 camera frame -> 8x4 output.
    run_frame(1'b1, 8);
    check("f2_writes", wr_cnt, 32);
    check("f2_last_addr", max_addr, 31);
    check("f2_done", done_cnt, 1);
    check("f2_frame_cnt", 32'(frame_cnt), 32'd1);
    check("f2_busy_after", 32'(busy), 32'd0);
    check("f2_sb_empty", sb_q.size(), 0);

    // Frame 3: short line, 3-byte line, over-long line.
    line_len[2] = 2 * CAM_W - 2;
    line_len[4] = 3;
    line_len[6] = 2 * CAM_W + 8;
    run_frame(1'b1, 8);
    check("f3_writes", wr_cnt, 25);
    check("f3_frame_cnt", 32'(frame_cnt), 32'd2);
    repeat (5) step();
    check("f3_line_err_sticky", 32'(line_err), 32'd1);

    // Frame 4: clean again, with surplus camera lines beyond V_RES.
    for (int y = 0; y < 16; y++) line_len[y] = 2 * CAM_W;
    run_frame(1'b1, 10);
    check("f4_writes", wr_cnt, 32);
    check("f4_last_addr", max_addr, 31);
    check("f4_line_err", 32'(line_err), 32'd0);
    check("f4_frame_cnt", 32'(frame_cnt), 32'd3);
    check("f4_done", done_cnt, 3);

    // Reset in the middle of a captured frame.
    capture_en = 1'b1;
    vsync      = 1'b1;
    repeat (3) step();
    vsync = 1'b0;
    step();
    cap_on = 1'b1;
    wr_cnt = 0;
    step();
    drive_line(0, 2 * CAM_W, 3);
    drive_line(1, 2 * CAM_W, 3);
    drive_line(2, 10, 0);
    done_before = done_cnt;
    rst    = 1'b1;
    href   = 1'b0;
    cap_on = 1'b0;
    step();
    check_all_zero("midrst");
    check("midrst_writes", wr_cnt, 11);
    check("midrst_sb_empty", sb_q.size(), 0);
    vsync = 1'b1;
    repeat (3) step();
    rst = 1'b0;
    repeat (2) step();
    check("midrst_no_done", done_cnt, done_before);

    run_frame(1'b1, 8);
    check("post_rst_writes", wr_cnt, 32);
    check("post_rst_frame_cnt", 32'(frame_cnt), 32'd1);
    check("post_rst_done", done_cnt, done_before + 1);
    check("post_rst_sb_empty", sb_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
